// File: rtl/bsg_manycore_vcache_wh_pkg.sv
// Shared types for the vcache DMA wormhole endpoint: header layout macro, FSM states, packet lengths.
// Header fields are listed MSB first so that cord lands in the flit LSBs.
`ifndef BSG_MANYCORE_VCACHE_WH_HEADER_S
`define BSG_MANYCORE_VCACHE_WH_HEADER_S
`define DECLARE_BSG_MANYCORE_VCACHE_WH_HEADER_S(cord_w, len_w, cid_w, name) \
  typedef struct packed { \
    logic              write_not_read; \
    logic [cid_w-1:0]  src_cid; \
    logic [cord_w-1:0] src_cord; \
    logic [cid_w-1:0]  cid; \
    logic [len_w-1:0]  len; \
    logic [cord_w-1:0] cord; \
  } name
`endif

package bsg_manycore_vcache_wh_pkg;

  typedef enum logic [2:0] {
    e_idle,
    e_addr,
    e_wdata,
    e_rhdr,
    e_rdata,
    e_drain
  } wh_dma_state_e;

  localparam int wh_read_len_gp = 1;

  function automatic int wh_write_len(input int burst_len);
    return 1 + burst_len;
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear together with up restarts at init+1.
// Single-cycle update, no handshake.
module bsg_counter_clear_up #(
  parameter int max_val_p  = 4,
  parameter int init_val_p = 0,
  localparam int width_lp  = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_o <= width_lp'(init_val_p);
    else if (clear_i)
      count_o <= width_lp'(init_val_p) + width_lp'(up_i);
    else if (up_i)
      count_o <= count_o + width_lp'(1);
  end

endmodule

// File: rtl/bsg_two_fifo.sv
// Two-entry valid/ready fifo: one cycle enqueue-to-valid, full throughput with both entries.
// ready_o drops only when both entries are occupied; output is consumed on v_o & yumi_i.
module bsg_two_fifo #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_r [2];
  logic wptr_r, rptr_r, full_r, empty_r, enq, deq;

  assign ready_o = ~full_r;
  assign v_o     = ~empty_r;
  assign data_o  = mem_r[rptr_r];
  assign enq     = v_i & ~full_r;
  assign deq     = yumi_i & ~empty_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (enq) wptr_r <= ~wptr_r;
      if (deq) rptr_r <= ~rptr_r;
      if (enq & ~deq) begin
        empty_r <= 1'b0;
        full_r  <= (~wptr_r == rptr_r);
      end else if (deq & ~enq) begin
        full_r  <= 1'b0;
        empty_r <= (~rptr_r == wptr_r);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_vcache_wh_dma_responder.sv
// Memory-side DMA endpoint: wormhole requests -> beat memory port, read data -> response packets.
// First mem cmd 2 cycles after header; writes pass through zero-latency; BSG_MANYCORE_VCACHE_WH_DMA_RESP_CHECK_EN adds len checking.
module bsg_manycore_vcache_wh_dma_responder
  import bsg_manycore_vcache_wh_pkg::*;
#(
  parameter int wh_flit_width_p  = 32,
  parameter int wh_cord_width_p  = 7,
  parameter int wh_len_width_p   = 4,
  parameter int wh_cid_width_p   = 2,
  parameter int dma_addr_width_p = 28,
  parameter int dma_burst_len_p  = 4,
  localparam int link_width_lp   = wh_flit_width_p + 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [link_width_lp-1:0]    wh_link_sif_i,
  output logic [link_width_lp-1:0]    wh_link_sif_o,
  output logic                        mem_v_o,
  output logic                        mem_w_o,
  output logic [dma_addr_width_p-1:0] mem_addr_o,
  output logic [wh_flit_width_p-1:0]  mem_data_o,
  input  logic                        mem_ready_i,
  input  logic                        mem_data_v_i,
  input  logic [wh_flit_width_p-1:0]  mem_data_i,
  output logic                        mem_data_yumi_o,
  output logic                        err_o
);

  `DECLARE_BSG_MANYCORE_VCACHE_WH_HEADER_S(wh_cord_width_p, wh_len_width_p, wh_cid_width_p, wh_hdr_s);

  localparam int hdr_width_lp  = $bits(wh_hdr_s);
  localparam int cnt_width_lp  = $clog2(dma_burst_len_p + 1);
  localparam int beat_shift_lp = $clog2(wh_flit_width_p / 8);
  localparam logic [cnt_width_lp-1:0] burst_lp     = cnt_width_lp'(dma_burst_len_p);
  localparam logic [cnt_width_lp-1:0] last_beat_lp = cnt_width_lp'(dma_burst_len_p - 1);

  logic in_v, in_ready, out_ready;
  logic [wh_flit_width_p-1:0] in_data;
  assign in_v      = wh_link_sif_i[link_width_lp-1];
  assign out_ready = wh_link_sif_i[wh_flit_width_p];
  assign in_data   = wh_link_sif_i[wh_flit_width_p-1:0];

  wh_dma_state_e state_r, state_n;
  wh_hdr_s in_hdr, hdr_r, resp_hdr;
  logic [dma_addr_width_p-1:0] addr_r;
  logic [wh_len_width_p-1:0] drain_r;
  logic [cnt_width_lp-1:0] issue_cnt, ret_cnt;
  logic issue_clear, ret_clear, hdr_bad, hdr_take;
  logic fifo_v_li, fifo_ready_lo, fifo_v_lo;
  logic [wh_flit_width_p-1:0] fifo_data_li, fifo_data_lo;

  assign in_hdr   = in_data[hdr_width_lp-1:0];
  assign hdr_take = (state_r == e_idle) & in_v & in_ready;

`ifdef BSG_MANYCORE_VCACHE_WH_DMA_RESP_CHECK_EN
  logic err_r;
  assign hdr_bad = in_hdr.len != (in_hdr.write_not_read
                   ? wh_len_width_p'(wh_write_len(dma_burst_len_p))
                   : wh_len_width_p'(wh_read_len_gp));
  always_ff @(posedge clk_i) begin
    if (reset_i) err_r <= 1'b0;
    else if (hdr_take & hdr_bad) err_r <= 1'b1;
  end
  assign err_o = err_r;
`else
  assign hdr_bad = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    resp_hdr      = '0;
    resp_hdr.cord = hdr_r.src_cord;
    resp_hdr.len  = wh_len_width_p'(dma_burst_len_p);
    resp_hdr.cid  = hdr_r.src_cid;
  end

  always_comb begin
    state_n         = state_r;
    in_ready        = 1'b0;
    mem_v_o         = 1'b0;
    mem_w_o         = 1'b0;
    mem_data_yumi_o = 1'b0;
    fifo_v_li       = 1'b0;
    fifo_data_li    = '0;
    issue_clear     = 1'b0;
    ret_clear       = 1'b0;
    case (state_r)
      e_idle: begin
        in_ready = 1'b1;
        if (in_v)
          state_n = !hdr_bad ? e_addr : (in_hdr.len == '0) ? e_idle : e_drain;
      end
      e_addr: begin
        in_ready = 1'b1;
        if (in_v) state_n = hdr_r.write_not_read ? e_wdata : e_rhdr;
      end
      e_wdata: begin
        mem_v_o  = in_v;
        mem_w_o  = 1'b1;
        in_ready = mem_ready_i;
        if (in_v & mem_ready_i & (issue_cnt == last_beat_lp)) begin
          issue_clear = 1'b1;
          state_n     = e_idle;
        end
      end
      e_rhdr: begin
        mem_v_o      = issue_cnt != burst_lp;
        fifo_v_li    = 1'b1;
        fifo_data_li = wh_flit_width_p'(resp_hdr);
        if (fifo_ready_lo) state_n = e_rdata;
      end
      e_rdata: begin
        // Commands keep issuing while earlier beats drain into the response fifo.
        mem_v_o         = issue_cnt != burst_lp;
        fifo_v_li       = mem_data_v_i;
        fifo_data_li    = mem_data_i;
        mem_data_yumi_o = mem_data_v_i & fifo_ready_lo;
        if (mem_data_yumi_o & (ret_cnt == last_beat_lp)) begin
          issue_clear = 1'b1;
          ret_clear   = 1'b1;
          state_n     = e_idle;
        end
      end
      e_drain: begin
        in_ready = 1'b1;
        if (in_v & (drain_r == wh_len_width_p'(1))) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
    if (reset_i) begin
      in_ready        = 1'b0;
      mem_v_o         = 1'b0;
      mem_data_yumi_o = 1'b0;
      fifo_v_li       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  always_ff @(posedge clk_i) begin
    if (hdr_take) begin
      hdr_r   <= in_hdr;
      drain_r <= in_hdr.len;
    end else if ((state_r == e_drain) & in_v) begin
      drain_r <= drain_r - wh_len_width_p'(1);
    end
    if ((state_r == e_addr) & in_v & in_ready)
      addr_r <= in_data[dma_addr_width_p-1:0];
  end

  bsg_counter_clear_up #(.max_val_p(dma_burst_len_p), .init_val_p(0)) issue_ctr (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(issue_clear),
    .up_i(mem_v_o & mem_ready_i & ~issue_clear), .count_o(issue_cnt)
  );

  bsg_counter_clear_up #(.max_val_p(dma_burst_len_p), .init_val_p(0)) ret_ctr (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(ret_clear),
    .up_i(mem_data_yumi_o & ~ret_clear), .count_o(ret_cnt)
  );

  // Truncation to the address width gives the wrap-around across the top of memory.
  assign mem_addr_o = addr_r + (dma_addr_width_p'(issue_cnt) << beat_shift_lp);
  assign mem_data_o = in_data;

  bsg_two_fifo #(.width_p(wh_flit_width_p)) out_fifo (
    .clk_i(clk_i), .reset_i(reset_i),
    .ready_o(fifo_ready_lo), .data_i(fifo_data_li), .v_i(fifo_v_li),
    .v_o(fifo_v_lo), .data_o(fifo_data_lo), .yumi_i(fifo_v_lo & out_ready)
  );

  assign wh_link_sif_o = {fifo_v_lo, in_ready, fifo_data_lo};

  logic unused;
  assign unused = ^{hdr_r.cord, hdr_r.cid, hdr_r.len};

endmodule

// File: tb/tb_bsg_manycore_vcache_wh_dma_responder.sv
// Randomized bench with a queue-based packet model for the vcache DMA wormhole responder.
`timescale 1ns/1ps
module tb_bsg_manycore_vcache_wh_dma_responder;
  localparam int W = 32, AW = 28, BL = 4, LW = W + 2;

  logic clk = 1'b0, reset = 1'b1;
  logic [LW-1:0] link_i, link_o;
  logic in_v, out_ready, mem_v, mem_w, mem_ready, mem_data_v, mem_yumi, err;
  logic [W-1:0] in_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  assign link_i = {in_v, out_ready, in_data};
  always #5 clk = ~clk;

  bsg_manycore_vcache_wh_dma_responder dut (
    .clk_i(clk), .reset_i(reset), .wh_link_sif_i(link_i), .wh_link_sif_o(link_o),
    .mem_v_o(mem_v), .mem_w_o(mem_w), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_ready_i(mem_ready), .mem_data_v_i(mem_data_v), .mem_data_i(mem_rdata),
    .mem_data_yumi_o(mem_yumi), .err_o(err)
  );

  typedef struct { bit w; bit [AW-1:0] addr; bit [W-1:0] data; } cmd_t;
  cmd_t exp_cmd[$], got_cmd[$];
  bit [W-1:0] exp_out[$], got_out[$], in_q[$], ret_q[$];
  int n_checks = 0, n_fail = 0;
  int in_mode = 0, mem_mode = 0, out_mode = 0, cyc = 0;
  bit hs_in, hs_cmd, hs_ret, hs_out, ok;

  function automatic bit [W-1:0] rd_val(bit [AW-1:0] a);
    return {4'h9, a} ^ 32'h0F0F_5A5A;
  endfunction

  function automatic bit [W-1:0] mk_hdr(int cord, int len, int cid, int scord, int scid, int wnr);
    return W'(cord + (len << 7) + (cid << 11) + (scord << 13) + (scid << 20) + (wnr << 22));
  endfunction

  // Link, memory and sink models: sample at negedge, update drives 1ns after posedge.
  initial begin
    in_v = 0; in_data = '0; out_ready = 0; mem_ready = 0; mem_data_v = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      hs_in  = in_v & link_o[W];
      hs_cmd = mem_v & mem_ready;
      hs_ret = mem_data_v & mem_yumi;
      hs_out = link_o[LW-1] & out_ready;
      if (!reset) begin
        if (hs_cmd) begin
          got_cmd.push_back('{w: mem_w, addr: mem_addr, data: (mem_w ? mem_wdata : '0)});
          if (!mem_w) ret_q.push_back(rd_val(mem_addr));
        end
        if (hs_out) got_out.push_back(link_o[W-1:0]);
      end
      @(posedge clk); #1; cyc++;
      if (reset) begin
        in_q.delete(); ret_q.delete(); got_cmd.delete(); got_out.delete();
        in_v = 0; mem_data_v = 0;
      end else begin
        if (hs_in) void'(in_q.pop_front());
        if (hs_ret) void'(ret_q.pop_front());
      end
      if (!(in_v && !hs_in)) in_v = (in_q.size() > 0) && (in_mode == 0 || $urandom_range(3) != 0);
      in_data = (in_q.size() > 0) ? in_q[0] : '0;
      mem_ready = (mem_mode == 0) ? 1'b1 : (mem_mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(1));
      out_ready = (out_mode == 0) ? 1'b1 : (out_mode == 1) ? 1'(cyc[0]) : 1'($urandom_range(1));
      if (!(mem_data_v && !hs_ret))
        mem_data_v = (ret_q.size() > 0) && (mem_mode != 2 || $urandom_range(1) != 0);
      mem_rdata = (ret_q.size() > 0) ? ret_q[0] : '0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk); reset = 1;
    exp_cmd.delete(); exp_out.delete();
    repeat (3) @(negedge clk);
    reset = 0;
  endtask

  task automatic send_read(int scord, int scid, bit [AW-1:0] addr);
    bit [AW-1:0] a;
    in_q.push_back(mk_hdr($urandom_range(127), 1, $urandom_range(3), scord, scid, 0));
    in_q.push_back(W'(addr));
    exp_out.push_back(mk_hdr(scord, BL, scid, 0, 0, 0));
    for (int b = 0; b < BL; b++) begin
      a = addr + AW'(4 * b);
      exp_cmd.push_back('{w: 1'b0, addr: a, data: '0});
      exp_out.push_back(rd_val(a));
    end
  endtask

  task automatic send_write(int scord, int scid, bit [AW-1:0] addr, bit [W-1:0] base);
    in_q.push_back(mk_hdr($urandom_range(127), 1 + BL, $urandom_range(3), scord, scid, 1));
    in_q.push_back(W'(addr));
    for (int b = 0; b < BL; b++) begin
      in_q.push_back(base + W'(b));
      exp_cmd.push_back('{w: 1'b1, addr: addr + AW'(4 * b), data: base + W'(b)});
    end
  endtask

  task automatic wait_done(output bit done);
    int n = 0;
    while ((in_q.size() != 0 || ret_q.size() != 0 || got_cmd.size() < exp_cmd.size() ||
            got_out.size() < exp_out.size()) && n < 4000) begin
      @(posedge clk); n++;
    end
    done = (n < 4000);
    repeat (20) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_mode = 0; mem_mode = 0; out_mode = 0;
    do_reset();
    send_read(1, 1, 28'h0000400);
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    n_checks++; if (link_o[W] !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", link_o[W]); end
    n_checks++; if (mem_v !== 1'b0) begin n_fail++; $display("FAIL reset_mem_v: got %b want 0", mem_v); end
    n_checks++; if (mem_yumi !== 1'b0) begin n_fail++; $display("FAIL reset_yumi: got %b want 0", mem_yumi); end
    n_checks++; if (link_o[LW-1] !== 1'b0) begin n_fail++; $display("FAIL reset_out_v: got %b want 0", link_o[LW-1]); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    repeat (2) @(negedge clk);
    exp_cmd.delete(); exp_out.delete();
    reset = 0;
    @(negedge clk);
    n_checks++; if (link_o[W] !== 1'b1) begin n_fail++; $display("FAIL reset_idle_ready: got %b want 1", link_o[W]); end
    n_checks++; if (mem_v !== 1'b0) begin n_fail++; $display("FAIL reset_idle_mem_v: got %b want 0", mem_v); end
  endtask

  task automatic test_write();
    in_mode = 0; mem_mode = 0; out_mode = 0;
    do_reset();
    send_write(3, 1, 28'h0000100, 32'h0000_00A0);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL write_timeout: cmds %0d want %0d", got_cmd.size(), exp_cmd.size()); end
    n_checks++; if (got_cmd.size() != exp_cmd.size()) begin n_fail++; $display("FAIL write_ncmd: got %0d want %0d", got_cmd.size(), exp_cmd.size()); end
    n_checks++; if (got_out.size() != 0) begin n_fail++; $display("FAIL write_no_resp: got %0d flits want 0", got_out.size()); end
    for (int i = 0; i < exp_cmd.size() && i < got_cmd.size(); i++) begin
      n_checks++;
      if (got_cmd[i] != exp_cmd[i]) begin n_fail++;
        $display("FAIL write_cmd[%0d]: got w=%0d a=%h d=%h want w=%0d a=%h d=%h", i, got_cmd[i].w, got_cmd[i].addr, got_cmd[i].data, exp_cmd[i].w, exp_cmd[i].addr, exp_cmd[i].data); end
    end
  endtask

  // Shared by the read-shaped scenarios: selects modes, runs the packets built by 'kind', compares.
  task automatic run_read_scenario(string tname, int kind);
    do_reset();
    case (kind)
      0: send_read(5, 2, 28'h0000200);
      1: send_read(6, 3, 28'hFFFFFF8);
      2: begin send_write(2, 0, 28'h0000300, 32'h1234_0000); send_read(4, 1, 28'h0000300); end
      3: for (int p = 0; p < 5; p++)
           if (p % 2 == 0) send_read($urandom_range(127), $urandom_range(3), AW'($urandom) & ~AW'(3));
           else send_write($urandom_range(127), $urandom_range(3), AW'($urandom) & ~AW'(3), $urandom);
      default: for (int p = 0; p < 20; p++)
           if ($urandom_range(1) != 0) send_read($urandom_range(127), $urandom_range(3), AW'($urandom) & ~AW'(3));
           else send_write($urandom_range(127), $urandom_range(3), AW'($urandom) & ~AW'(3), $urandom);
    endcase
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL %s_timeout: cmds %0d/%0d flits %0d/%0d", tname, got_cmd.size(), exp_cmd.size(), got_out.size(), exp_out.size()); end
    n_checks++; if (got_cmd.size() != exp_cmd.size()) begin n_fail++; $display("FAIL %s_ncmd: got %0d want %0d", tname, got_cmd.size(), exp_cmd.size()); end
    n_checks++; if (got_out.size() != exp_out.size()) begin n_fail++; $display("FAIL %s_nflit: got %0d want %0d", tname, got_out.size(), exp_out.size()); end
    for (int i = 0; i < exp_cmd.size() && i < got_cmd.size(); i++) begin
      n_checks++;
      if (got_cmd[i] != exp_cmd[i]) begin n_fail++;
        $display("FAIL %s_cmd[%0d]: got w=%0d a=%h d=%h want w=%0d a=%h d=%h", tname, i, got_cmd[i].w, got_cmd[i].addr, got_cmd[i].data, exp_cmd[i].w, exp_cmd[i].addr, exp_cmd[i].data); end
    end
    for (int i = 0; i < exp_out.size() && i < got_out.size(); i++) begin
      n_checks++;
      if (got_out[i] !== exp_out[i]) begin n_fail++; $display("FAIL %s_flit[%0d]: got %h want %h", tname, i, got_out[i], exp_out[i]); end
    end
  endtask

  task automatic test_read();
    in_mode = 0; mem_mode = 0; out_mode = 0;
    run_read_scenario("read", 0);
  endtask

  task automatic test_wrap();
    in_mode = 0; mem_mode = 2; out_mode = 0;
    run_read_scenario("wrap", 1);
  endtask

  task automatic test_back_to_back();
    in_mode = 0; mem_mode = 0; out_mode = 0;
    run_read_scenario("b2b", 2);
  endtask

  task automatic test_backpressure();
    in_mode = 0; mem_mode = 1; out_mode = 1;
    run_read_scenario("bp", 3);
  endtask

  task automatic test_random();
    in_mode = 1; mem_mode = 2; out_mode = 2;
    run_read_scenario("rand", 4);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rand_err: got %b want 0", err); end
  endtask

`ifdef BSG_MANYCORE_VCACHE_WH_DMA_RESP_CHECK_EN
  task automatic test_len_check();
    in_mode = 0; mem_mode = 0; out_mode = 0;
    do_reset();
    in_q.push_back(mk_hdr(0, 3, 0, 3, 1, 1));
    for (int i = 0; i < 3; i++) in_q.push_back($urandom);
    repeat (3) @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL lenchk_err: got %b want 1", err); end
    wait_done(ok);
    n_checks++; if (got_cmd.size() != 0 || got_out.size() != 0) begin n_fail++; $display("FAIL lenchk_quiet: got %0d cmds %0d flits want 0 0", got_cmd.size(), got_out.size()); end
    send_read(5, 2, 28'h0000A00);
    wait_done(ok);
    n_checks++; if (!ok || got_cmd.size() != BL) begin n_fail++; $display("FAIL lenchk_read_ncmd: got %0d want %0d", got_cmd.size(), BL); end
    for (int i = 0; i < exp_out.size() && i < got_out.size(); i++) begin
      n_checks++;
      if (got_out[i] !== exp_out[i]) begin n_fail++; $display("FAIL lenchk_flit[%0d]: got %h want %h", i, got_out[i], exp_out[i]); end
    end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL lenchk_sticky: got %b want 1", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_random();
`ifdef BSG_MANYCORE_VCACHE_WH_DMA_RESP_CHECK_EN
    test_len_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
